// File: rtl/axi_lite_reg_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_reg_slave
//
// AXI4-Lite responder holding NUM_REGS 32-bit read/write control registers.
// AW and W are captured independently in either order. A write commits once
// both are held and no write response is pending. Byte strobes are applied at
// commit. The read path is a single registered response stage that runs
// independently of the write path. Register contents and per-register
// one-cycle commit pulses are exported to fabric logic.
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESETN  clock, asynchronous active-low reset
//   S_AXI_AW* / S_AXI_W*       write address / write data channels
//   S_AXI_B*                   write response channel (OKAY / SLVERR)
//   S_AXI_AR* / S_AXI_R*       read address / read data channels
//   regs_out                   register i at bits [32*i+31:32*i]
//   wr_pulse                   one-cycle strobe for register i on commit
// -----------------------------------------------------------------------------
module axi_lite_reg_slave #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS       = 8
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]        regs_out,
    output logic [NUM_REGS-1:0]           wr_pulse
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    // First byte address past the register bank; anything at or above is SLVERR.
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_LIMIT = AXI_ADDR_WIDTH'(4 * NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [AXI_DATA_WIDTH-1:0] word_t;

    // Write path state
    logic                      aw_full_q, aw_full_d;
    logic                      w_full_q,  w_full_d;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
    word_t                     wdata_q,   wdata_d;
    logic [STRB_W-1:0]         wstrb_q,   wstrb_d;
    logic                      bvalid_q,  bvalid_d;
    logic [1:0]                bresp_q,   bresp_d;
    logic [NUM_REGS-1:0]       wr_pulse_q, wr_pulse_d;
    word_t                     regs_q [NUM_REGS];
    word_t                     regs_d [NUM_REGS];

    // Read path state
    logic                      rvalid_q, rvalid_d;
    word_t                     rdata_q,  rdata_d;
    logic [1:0]                rresp_q,  rresp_d;

    // Low while in reset and for the first edge after release, so every ready
    // output is 0 under reset and the block wakes up on a clean clock edge.
    logic                      active_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
    logic wr_in_range, rd_in_range;
    logic [IDX_W-1:0] wr_idx, rd_idx;

    // PROT is accepted for protocol compliance but has no effect here.
    logic unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    assign S_AXI_AWREADY = active_q && !aw_full_q && !bvalid_q;
    assign S_AXI_WREADY  = active_q && !w_full_q  && !bvalid_q;
    assign S_AXI_ARREADY = active_q && !rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign wr_pulse      = wr_pulse_q;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID  && S_AXI_WREADY;
    assign b_hs   = bvalid_q      && S_AXI_BREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_hs   = rvalid_q      && S_AXI_RREADY;
    assign commit = aw_full_q && w_full_q && !bvalid_q;

    assign wr_in_range = (awaddr_q < ADDR_LIMIT);
    assign rd_in_range = (S_AXI_ARADDR < ADDR_LIMIT);
    assign wr_idx      = awaddr_q[2 +: IDX_W];
    assign rd_idx      = S_AXI_ARADDR[2 +: IDX_W];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_out
        assign regs_out[32*i +: 32] = regs_q[i];
    end

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        aw_full_d  = aw_full_q;
        w_full_d   = w_full_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            awaddr_d  = S_AXI_AWADDR;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
        end

        // Capture and commit never coincide: both readies are low while the
        // corresponding buffer is full.
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (wr_in_range) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wstrb_q[b]) begin
                        regs_d[wr_idx][8*b +: 8] = wdata_q[8*b +: 8];
                    end
                end
                wr_pulse_d[wr_idx] = 1'b1;
                bresp_d            = RESP_OKAY;
            end else begin
                bresp_d = RESP_SLVERR;
            end
        end else if (b_hs) begin
            bvalid_d = 1'b0;
        end

        // Reads sample regs_q, so a same-edge commit is not yet visible.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_in_range ? regs_q[rd_idx] : '0;
            rresp_d  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (r_hs) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            active_q   <= 1'b0;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            wr_pulse_q <= '0;
            // NOTE: this is a small flop bank with defined power-up contents,
            // not a RAM, so it is reset like any other control state.
            regs_q     <= '{default: '0};
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values computed by the combinational block.
            active_q   <= 1'b1;
            aw_full_q  <= aw_full_d;
            w_full_q   <= w_full_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_reg_slave
//
// Directed bench for axi_lite_reg_slave (NUM_REGS = 8). Expected write and
// read responses are pushed to scoreboard queues when the stimulus is driven,
// computed from a reference register model, and popped when the DUT responds.
// -----------------------------------------------------------------------------
module tb_axi_lite_reg_slave;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [AW-1:0]     awaddr = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [DW-1:0]     wdata = '0;
    logic [DW/8-1:0]   wstrb = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b1;
    logic [AW-1:0]     araddr = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b1;
    logic [NR*32-1:0]  regs_out;
    logic [NR-1:0]     wr_pulse;

    always #5 clk = ~clk;

    axi_lite_reg_slave #(
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW),
        .NUM_REGS      (NR)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (3'b000),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (3'b000),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .regs_out     (regs_out),
        .wr_pulse     (wr_pulse)
    );

    typedef struct packed {
        logic [1:0]    resp;
        logic [NR-1:0] pulse;
    } b_exp_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    b_exp_t      bq[$];
    r_exp_t      rq[$];
    logic [31:0] model [NR];
    int          checks   = 0;
    int          failures = 0;
    int          lat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: update registers and queue the expected B response.
    task automatic expect_write(input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] strb);
        b_exp_t      e;
        logic [2:0]  idx;
        idx = addr[4:2];
        if (addr < 32'(4 * NR)) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
            end
            e.resp  = 2'b00;
            e.pulse = NR'(1) << idx;
        end else begin
            e.resp  = 2'b10;
            e.pulse = '0;
        end
        bq.push_back(e);
    endtask

    task automatic expect_read(input logic [31:0] addr);
        r_exp_t     e;
        logic [2:0] idx;
        idx = addr[4:2];
        if (addr < 32'(4 * NR)) begin
            e.data = model[idx];
            e.resp = 2'b00;
        end else begin
            e.data = '0;
            e.resp = 2'b10;
        end
        rq.push_back(e);
    endtask

    // Channel drivers: valid goes up at a falling edge, ready is sampled at
    // that same falling edge, so the following rising edge is the handshake.
    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        @(negedge clk);
        awaddr  = a;
        awvalid = 1'b1;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        check("aw_ready_wait", 64'(awready), 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(negedge clk);
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        while (!wready && n < 20) begin @(negedge clk); n++; end
        check("w_ready_wait", 64'(wready), 64'd1);
        @(posedge clk); #1;
        wvalid = 1'b0;
    endtask

    task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(negedge clk);
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
        check("aw_w_ready_wait", 64'(awready && wready), 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n = 0;
        @(negedge clk);
        araddr  = a;
        arvalid = 1'b1;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        check("ar_ready_wait", 64'(arready), 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    // Wait for BVALID, pop the scoreboard and compare response, pulse and
    // register contents; with BREADY high also confirm a single-beat response.
    task automatic wait_b(output int n);
        b_exp_t e;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        check("bvalid_wait", 64'(bvalid), 64'd1);
        e = bq.pop_front();
        check("bresp", 64'(bresp), 64'(e.resp));
        check("wr_pulse", 64'(wr_pulse), 64'(e.pulse));
        for (int i = 0; i < NR; i++) begin
            check($sformatf("reg%0d", i), 64'(regs_out[32*i +: 32]), 64'(model[i]));
        end
        if (bready) begin
            @(negedge clk);
            check("bvalid_drop", 64'(bvalid), 64'd0);
            check("wr_pulse_clear", 64'(wr_pulse), 64'd0);
        end
    endtask

    task automatic wait_r();
        r_exp_t e;
        int     n = 0;
        @(negedge clk);
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        check("rvalid_wait", 64'(rvalid), 64'd1);
        e = rq.pop_front();
        check("rdata", 64'(rdata), 64'(e.data));
        check("rresp", 64'(rresp), 64'(e.resp));
        if (rready) begin
            @(negedge clk);
            check("rvalid_drop", 64'(rvalid), 64'd0);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        expect_write(a, d, s);
        send_aw_w(a, d, s);
        wait_b(n);
    endtask

    task automatic do_read(input logic [31:0] a);
        expect_read(a);
        send_ar(a);
        wait_r();
    endtask

    initial begin
        for (int i = 0; i < NR; i++) model[i] = '0;

        // Reset state, then release away from a clock edge.
        #3;
        check("rst_ctrl", 64'({awready, wready, bvalid, bresp, arready, rvalid, rresp, wr_pulse}), 64'd0);
        check("rst_regs_any", 64'(|regs_out), 64'd0);
        #9 rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        check("ready_after_rst", 64'({awready, wready, arready}), 64'b111);

        // AW + W in the same cycle; minimum latency is one cycle.
        expect_write(32'h04, 32'hA5A5_1234, 4'hF);
        send_aw_w(32'h04, 32'hA5A5_1234, 4'hF);
        wait_b(lat);
        check("b_latency", 64'(lat), 64'd1);

        // W arrives well before AW; only byte 0 is replaced.
        do_write(32'h08, 32'h1122_3344, 4'hF);
        expect_write(32'h08, 32'h0000_00FF, 4'h1);
        send_w(32'h0000_00FF, 4'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_commit_w_only", 64'({bvalid, wr_pulse}), 64'd0);
        end
        send_aw(32'h08);
        wait_b(lat);
        check("reg2_merged", 64'(regs_out[64 +: 32]), 64'h1122_33FF);

        // Out-of-range and boundary addresses.
        do_write(32'h40, 32'hFFFF_FFFF, 4'hF);
        do_write(32'h20, 32'hFFFF_FFFF, 4'hF);
        do_read(32'h40);
        do_write(32'h1C, 32'hCAFE_F00D, 4'hF);
        do_read(32'h1C);
        do_write(32'h0E, 32'h00AB_CD00, 4'h6);   // low address bits ignored -> reg3
        do_read(32'h0C);
        do_write(32'h18, 32'h1234_5678, 4'h0);   // zero strobe: OKAY + pulse, no change
        do_read(32'h08);

        // Read of reg1 on the same edge as the commit that overwrites it.
        do_write(32'h04, 32'h0000_0005, 4'hF);
        @(negedge clk);
        check("ready_before_race", 64'({awready, wready, arready}), 64'b111);
        awaddr  = 32'h04;
        wdata   = 32'hDEAD_BEEF;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        expect_read(32'h04);
        expect_write(32'h04, 32'hDEAD_BEEF, 4'hF);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        araddr  = 32'h04;
        arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        fork
            wait_r();
            wait_b(lat);
        join
        do_read(32'h04);

        // Back-pressure on both response channels for 10 cycles.
        bready = 1'b0;
        rready = 1'b0;
        expect_write(32'h14, 32'h5555_AAAA, 4'hF);
        expect_read(32'h1C);
        fork
            send_aw_w(32'h14, 32'h5555_AAAA, 4'hF);
            send_ar(32'h1C);
        join
        fork
            wait_b(lat);
            wait_r();
        join
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_ctrl", 64'({bvalid, bresp, rvalid, rresp, awready, wready, arready}),
                  64'b1_00_1_00_000);
            check("stall_rdata", 64'(rdata), 64'hCAFE_F00D);
        end
        bready = 1'b1;
        rready = 1'b1;
        @(negedge clk);
        check("stall_release", 64'({bvalid, rvalid}), 64'd0);

        // Reset with a buffered AW and a pending read response.
        rready = 1'b0;
        send_aw(32'h10);
        do_read(32'h14);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ctrl", 64'({awready, wready, bvalid, bresp, arready, rvalid, rresp, wr_pulse}), 64'd0);
        check("midrst_rdata", 64'(rdata), 64'd0);
        check("midrst_regs_any", 64'(|regs_out), 64'd0);
        rst_n  = 1'b1;
        rready = 1'b1;
        for (int i = 0; i < NR; i++) model[i] = '0;

        // The dropped AW must not pair with a new W.
        send_w(32'hFFFF_FFFF, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_stale_commit", 64'({bvalid, wr_pulse}), 64'd0);
        end
        for (int i = 0; i < NR; i++) do_read(32'(4 * i));
        expect_write(32'h00, 32'hFFFF_FFFF, 4'hF);
        send_aw(32'h00);
        wait_b(lat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
